// File: rtl/mc_pkg.sv
// Shared types and field encodings for the multicycle ARM bus controller.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BRANCH,
    HALT
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_EOR = 3'd4;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Compare-style ops set flags but never write a register.
  function automatic logic isCompare(input logic [3:0] cmd);
    return (cmd == CMD_CMP) || (cmd == CMD_TST);
  endfunction

endpackage

// File: rtl/mc_bus_controller_if.sv
// Controller <-> datapath/memory-bus signal bundle; master is the controller side.
interface mc_bus_controller_if #(
  parameter int ALUCTRL_W = 3
);
  logic [19:0]          Instr;
  logic [3:0]           ALUFlags;
  logic                 MemReady;
  logic                 MemReq;
  logic                 PCWrite;
  logic                 MemWrite;
  logic                 RegWrite;
  logic                 IRWrite;
  logic                 AdrSrc;
  logic                 ALUSrcA;
  logic [1:0]           RegSrc;
  logic [1:0]           ALUSrcB;
  logic [1:0]           ResultSrc;
  logic [1:0]           ImmSrc;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic                 BusErr;

  modport master (
    input  Instr, ALUFlags, MemReady,
    output MemReq, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
           RegSrc, ALUSrcB, ResultSrc, ImmSrc, ALUControl, BusErr
  );

  modport slave (
    output Instr, ALUFlags, MemReady,
    input  MemReq, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
           RegSrc, ALUSrcB, ResultSrc, ImmSrc, ALUControl, BusErr
  );
endinterface

// File: rtl/mc_condcheck.sv
// Combinational ARM condition-code evaluator; flags are {N,Z,C,V}, code 1111 is never.
module mc_condcheck
  import mc_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       condEx
);
  logic n, z, c, v;

  assign {n, z, c, v} = flags;

  always_comb begin
    condEx = 1'b0;
    unique case (cond)
      COND_EQ: condEx = z;
      COND_NE: condEx = !z;
      COND_CS: condEx = c;
      COND_CC: condEx = !c;
      COND_MI: condEx = n;
      COND_PL: condEx = !n;
      COND_VS: condEx = v;
      COND_VC: condEx = !v;
      COND_HI: condEx = c && !z;
      COND_LS: condEx = !c || z;
      COND_GE: condEx = (n == v);
      COND_LT: condEx = (n != v);
      COND_GT: condEx = !z && (n == v);
      COND_LE: condEx = z || (n != v);
      COND_AL: condEx = 1'b1;
      default: condEx = 1'b0;
    endcase
  end
endmodule

// File: rtl/mc_bus_controller.sv
// Multicycle ARM control unit with a ready-handshake memory bus and CMP/TST support.
// Optional MC_BUS_TIMEOUT_EN adds a bus wait-state watchdog that halts with a sticky BusErr.
module mc_bus_controller
  import mc_pkg::*;
#(
  parameter int ALUCTRL_W   = 3,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic          clk,
  input  logic          reset,
  mc_bus_controller_if.master bus
);
  state_t     state, nextState;
  logic [3:0] flags;
  logic       condExR;
  logic       condEx;
  logic       busReq;

  logic [3:0] cond;
  logic [1:0] op;
  logic       immBit;
  logic [3:0] cmd;
  logic       sBit;
  logic       rdIsPc;

  assign cond   = bus.Instr[19:16];
  assign op     = bus.Instr[15:14];
  assign immBit = bus.Instr[13];
  assign cmd    = bus.Instr[12:9];
  assign sBit   = bus.Instr[8];
  assign rdIsPc = (bus.Instr[3:0] == 4'hF);

  mc_condcheck u_condcheck (
    .cond   (cond),
    .flags  (flags),
    .condEx (condEx)
  );

  // Data-processing decode: ALU op, support (EOR needs the wider control), flag scope.
  logic [2:0] dpAluOp;
  logic       dpSupported;
  logic       dpWritesCV;
  logic       dpCompare;

  always_comb begin
    dpAluOp     = ALU_ADD;
    dpSupported = 1'b1;
    dpWritesCV  = 1'b0;
    unique case (cmd)
      CMD_ADD: begin dpAluOp = ALU_ADD; dpWritesCV = 1'b1; end
      CMD_SUB: begin dpAluOp = ALU_SUB; dpWritesCV = 1'b1; end
      CMD_CMP: begin dpAluOp = ALU_SUB; dpWritesCV = 1'b1; end
      CMD_AND: dpAluOp = ALU_AND;
      CMD_TST: dpAluOp = ALU_AND;
      CMD_ORR: dpAluOp = ALU_ORR;
      CMD_EOR: begin
        if (ALUCTRL_W >= 3) dpAluOp = ALU_EOR;
        else dpSupported = 1'b0;
      end
      default: dpSupported = 1'b0;
    endcase
    if (!dpSupported) dpAluOp = ALU_ADD;
  end

  assign dpCompare = isCompare(cmd);
  assign busReq    = (state == FETCH) || (state == MEMRD) || (state == MEMWR);

`ifdef MC_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] waitCnt;
  logic             busErr;
  logic             timeoutHit;

  assign timeoutHit = busReq && !bus.MemReady && (waitCnt == CNT_W'(TIMEOUT_CYC - 1));

  // Consecutive stalled request cycles; any ready or idle cycle restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      waitCnt <= '0;
      busErr  <= 1'b0;
    end else begin
      if (busReq && !bus.MemReady && !timeoutHit) waitCnt <= waitCnt + CNT_W'(1);
      else waitCnt <= '0;
      if (timeoutHit) busErr <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      flags   <= 4'b0000;
      condExR <= 1'b0;
    end else begin
      state <= nextState;
      if (state == DECODE) condExR <= condEx;
      if ((state == EXECUTER || state == EXECUTEI) && condExR && dpSupported &&
          (sBit || dpCompare)) begin
        flags[3:2] <= bus.ALUFlags[3:2];
        if (dpWritesCV) flags[1:0] <= bus.ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      FETCH:    if (bus.MemReady) nextState = DECODE;
      DECODE: begin
        unique case (op)
          OP_MEM:  nextState = MEMADR;
          OP_DP:   nextState = immBit ? EXECUTEI : EXECUTER;
          OP_BR:   nextState = BRANCH;
          default: nextState = FETCH;
        endcase
      end
      MEMADR: begin
        if (!condExR)  nextState = FETCH;
        else if (sBit) nextState = MEMRD;
        else           nextState = MEMWR;
      end
      MEMRD:    if (bus.MemReady) nextState = MEMWB;
      MEMWB:    nextState = FETCH;
      MEMWR:    if (bus.MemReady) nextState = FETCH;
      EXECUTER: nextState = ALUWB;
      EXECUTEI: nextState = ALUWB;
      ALUWB:    nextState = FETCH;
      BRANCH:   nextState = FETCH;
`ifdef MC_BUS_TIMEOUT_EN
      HALT:     nextState = HALT;
`endif
      default:  nextState = FETCH;
    endcase
`ifdef MC_BUS_TIMEOUT_EN
    if (timeoutHit) nextState = HALT;
`endif
  end

  // Selects are Moore; enables are additionally forced low during reset.
  logic [2:0] aluOp;

  always_comb begin
    bus.MemReq    = busReq;
    bus.PCWrite   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.ALUSrcA   = 1'b0;
    bus.ALUSrcB   = 2'b00;
    bus.ResultSrc = 2'b00;
    aluOp         = ALU_ADD;
    bus.RegSrc    = {(op == OP_MEM), (op == OP_BR)};
    bus.ImmSrc    = op;
`ifdef MC_BUS_TIMEOUT_EN
    bus.BusErr    = busErr;
`else
    bus.BusErr    = 1'b0;
`endif
    unique case (state)
      FETCH: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.IRWrite   = bus.MemReady;
        bus.PCWrite   = bus.MemReady;
      end
      DECODE: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      MEMADR:   bus.ALUSrcB = 2'b01;
      MEMRD:    bus.AdrSrc  = 1'b1;
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegWrite  = 1'b1;
        bus.PCWrite   = rdIsPc;
      end
      MEMWR: begin
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = 1'b1;
      end
      EXECUTER: aluOp = dpAluOp;
      EXECUTEI: begin
        bus.ALUSrcB = 2'b01;
        aluOp       = dpAluOp;
      end
      ALUWB: begin
        bus.RegWrite = condExR && !dpCompare && dpSupported;
        bus.PCWrite  = condExR && !dpCompare && dpSupported && rdIsPc;
      end
      BRANCH: begin
        bus.ALUSrcB   = 2'b01;
        bus.ResultSrc = 2'b10;
        bus.PCWrite   = condExR;
      end
      default: bus.MemReq = 1'b0;
    endcase
    if (reset) begin
      bus.PCWrite  = 1'b0;
      bus.MemWrite = 1'b0;
      bus.RegWrite = 1'b0;
      bus.IRWrite  = 1'b0;
    end
    bus.ALUControl = aluOp[ALUCTRL_W-1:0];
  end

endmodule

// File: tb/tb_mc_bus_controller.sv
// Directed scoreboard bench for mc_bus_controller (ALUCTRL_W=3 and ALUCTRL_W=2 instances).
module tb_mc_bus_controller;
  import mc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] instr;
  logic [3:0]  aluFlags;
  logic        memReady;

  always #5 clk = ~clk;

  mc_bus_controller_if #(.ALUCTRL_W(3)) bus3 ();
  mc_bus_controller_if #(.ALUCTRL_W(2)) bus2 ();

  assign bus3.Instr    = instr;
  assign bus3.ALUFlags = aluFlags;
  assign bus3.MemReady = memReady;
  assign bus2.Instr    = instr;
  assign bus2.ALUFlags = aluFlags;
  assign bus2.MemReady = memReady;

  mc_bus_controller #(.ALUCTRL_W(3), .TIMEOUT_CYC(15)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  mc_bus_controller #(.ALUCTRL_W(2), .TIMEOUT_CYC(15)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  // Control vector order: {MemReq, IRWrite, PCWrite, RegWrite, MemWrite, BusErr}
  localparam logic [5:0] IDLE    = 6'b000000;
  localparam logic [5:0] WAITREQ = 6'b100000;
  localparam logic [5:0] FETCHOK = 6'b111000;
  localparam logic [5:0] REGW    = 6'b000100;
  localparam logic [5:0] PCW     = 6'b001000;
  localparam logic [5:0] STORE   = 6'b100010;
  localparam logic [5:0] HALTED  = 6'b000001;

  typedef struct {
    string      tag;
    logic [5:0] ctl;
    logic [2:0] alu;
    logic       checkAlu;
  } exp_t;

  exp_t sbQ[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [5:0] ctl3();
    return {bus3.MemReq, bus3.IRWrite, bus3.PCWrite, bus3.RegWrite, bus3.MemWrite, bus3.BusErr};
  endfunction

  task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic rdy, input logic [5:0] ctl,
                               input logic [2:0] alu, input logic checkAlu);
    exp_t e;
    memReady = rdy;
    e.tag = tag; e.ctl = ctl; e.alu = alu; e.checkAlu = checkAlu;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    #1;
    e = sbQ.pop_front();
    checkVal({e.tag, ".ctl"}, {2'b00, ctl3()}, {2'b00, e.ctl});
    if (e.checkAlu) checkVal({e.tag, ".alu"}, {5'b0, bus3.ALUControl}, {5'b0, e.alu});
  endtask

  task automatic step(input string tag, input logic rdy, input logic [5:0] ctl,
                      input logic [2:0] alu = 3'd0, input logic checkAlu = 1'b0);
    applyStimulus(tag, rdy, ctl, alu, checkAlu);
    checkOutput();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; instr = 20'h0; aluFlags = 4'h0; memReady = 1'b0;
    @(negedge clk);
    // In reset with MemReady high: FETCH requests but no enables pulse.
    applyStimulus("reset", 1'b1, WAITREQ, 3'd0, 1'b0);
    checkOutput();
    checkVal("reset.flags", {4'b0, dut3.flags}, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    // ADD R1,R2,R3
    instr = 20'hE0821;
    step("add.fetch", 1'b1, FETCHOK, ALU_ADD, 1'b1);
    step("add.decode", 1'b1, IDLE);
    step("add.exec", 1'b1, IDLE, ALU_ADD, 1'b1);
    step("add.wb", 1'b1, REGW);

    // Reset asserted in ALUWB must suppress RegWrite, then restart at FETCH.
    step("addr.fetch", 1'b1, FETCHOK);
    step("addr.decode", 1'b1, IDLE);
    step("addr.exec", 1'b1, IDLE);
    reset = 1'b1;
    applyStimulus("addr.wbreset", 1'b1, IDLE, 3'd0, 1'b0);
    checkOutput();
    @(negedge clk);
    reset = 1'b0;
    checkVal("addr.state", 8'(dut3.state), 8'(FETCH));

    // LDR with 3 fetch wait states and 2 read wait states
    instr = 20'hE5921;
    for (int i = 0; i < 3; i++) step("ldr.fetchwait", 1'b0, WAITREQ);
    step("ldr.fetch", 1'b1, FETCHOK);
    step("ldr.decode", 1'b1, IDLE);
    step("ldr.memadr", 1'b1, IDLE, ALU_ADD, 1'b1);
    for (int i = 0; i < 2; i++) step("ldr.rdwait", 1'b0, WAITREQ);
    step("ldr.rd", 1'b1, WAITREQ);
    step("ldr.wb", 1'b0, REGW);

    // STR
    instr = 20'hE5821;
    step("str.fetch", 1'b1, FETCHOK);
    step("str.decode", 1'b1, IDLE);
    step("str.memadr", 1'b1, IDLE);
    step("str.wr", 1'b1, STORE);

    // SUBS R0,R0,#1 with Z=1, then BEQ taken
    instr = 20'hE2500; aluFlags = 4'b0110;
    step("subs1.fetch", 1'b1, FETCHOK);
    step("subs1.decode", 1'b1, IDLE);
    step("subs1.exec", 1'b1, IDLE, ALU_SUB, 1'b1);
    checkVal("subs1.flags", {4'b0, dut3.flags}, 8'h06);
    step("subs1.wb", 1'b1, REGW);
    instr = 20'h0A000; aluFlags = 4'b0000;
    step("beq1.fetch", 1'b1, FETCHOK);
    step("beq1.decode", 1'b1, IDLE);
    step("beq1.branch", 1'b1, PCW);

    // Same with Z=0: branch not taken
    instr = 20'hE2500; aluFlags = 4'b0010;
    step("subs0.fetch", 1'b1, FETCHOK);
    step("subs0.decode", 1'b1, IDLE);
    step("subs0.exec", 1'b1, IDLE, ALU_SUB, 1'b1);
    step("subs0.wb", 1'b1, REGW);
    checkVal("subs0.flags", {4'b0, dut3.flags}, 8'h02);
    instr = 20'h0A000; aluFlags = 4'b0000;
    step("beq0.fetch", 1'b1, FETCHOK);
    step("beq0.decode", 1'b1, IDLE);
    step("beq0.branch", 1'b1, IDLE);

    // CMP R1,#5 sets all four flags and suppresses writeback
    instr = 20'hE3510; aluFlags = 4'b0110;
    step("cmp.fetch", 1'b1, FETCHOK);
    step("cmp.decode", 1'b1, IDLE);
    step("cmp.exec", 1'b1, IDLE, ALU_SUB, 1'b1);
    step("cmp.wb", 1'b1, IDLE);
    checkVal("cmp.flags", {4'b0, dut3.flags}, 8'h06);

    // EOR R1,R2,R3: supported at width 3, NOP at width 2
    instr = 20'hE0221; aluFlags = 4'b0000;
    step("eor.fetch", 1'b1, FETCHOK);
    step("eor.decode", 1'b1, IDLE);
    applyStimulus("eor.exec", 1'b1, IDLE, ALU_EOR, 1'b1);
    checkOutput();
    checkVal("eor2.alu", {6'b0, bus2.ALUControl}, 8'h00);
    @(negedge clk);
    applyStimulus("eor.wb", 1'b1, REGW, 3'd0, 1'b0);
    checkOutput();
    checkVal("eor2.regwrite", {7'b0, bus2.RegWrite}, 8'h00);
    @(negedge clk);

    // EORS with N=1: width 3 updates N,Z only; width 2 leaves flags alone
    instr = 20'hE0321; aluFlags = 4'b1000;
    step("eors.fetch", 1'b1, FETCHOK);
    step("eors.decode", 1'b1, IDLE);
    step("eors.exec", 1'b1, IDLE, ALU_EOR, 1'b1);
    step("eors.wb", 1'b1, REGW);
    checkVal("eors3.flags", {4'b0, dut3.flags}, 8'h0A);
    checkVal("eors2.flags", {4'b0, dut2.flags}, 8'h06);

`ifdef MC_BUS_TIMEOUT_EN
    // Fetch never acknowledged: 15 stalled cycles, then HALT with BusErr
    instr = 20'hE0821;
    for (int i = 0; i < 15; i++) step("tmo.wait", 1'b0, WAITREQ);
    applyStimulus("tmo.halt", 1'b0, HALTED, 3'd0, 1'b0);
    checkOutput();
    checkVal("tmo.state", 8'(dut3.state), 8'(HALT));
    @(negedge clk);
    step("tmo.halt2", 1'b1, HALTED);
    reset = 1'b1;
    step("tmo.reset", 1'b0, HALTED);
    reset = 1'b0;
    checkVal("tmo.state2", 8'(dut3.state), 8'(FETCH));
    step("tmo.fetch", 1'b1, FETCHOK);
`else
    // Without the watchdog a stalled fetch waits indefinitely
    instr = 20'hE0821;
    for (int i = 0; i < 20; i++) step("nowdt.wait", 1'b0, WAITREQ);
    step("nowdt.fetch", 1'b1, FETCHOK);
    checkVal("nowdt.state", 8'(dut3.state), 8'(DECODE));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_bus_controller.md
Name: mc_bus_controller

Overview:
- Multicycle ARM control unit, next generation of the current controller: explicit-state main FSM plus condition logic in one block.
- Adds a memory-bus ready handshake with wait states and a parametrised ALU-control width (adds EOR).
- Adds CMP/TST-style compare ops with writeback suppressed, and an optional bus-timeout error.
- Sits between instruction register/flags in the datapath and the datapath mux/enable controls.

Parameters:
- ALUCTRL_W, 3, ALUControl width; 2 = ADD/SUB/AND/ORR only, 3 adds EOR.
- TIMEOUT_CYC, 15, maximum consecutive not-ready bus cycles before error (BUS_TIMEOUT_EN only).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- Instr  in  20  IR bits [31:12]
- ALUFlags  in  4  N,Z,C,V from ALU
- MemReady  in  1  bus acknowledge for current request
- MemReq  out  1  bus request (fetch/load/store)
- PCWrite, MemWrite, RegWrite, IRWrite  out  1 each  enables
- AdrSrc, ALUSrcA  out  1 each  mux selects
- RegSrc, ALUSrcB, ResultSrc, ImmSrc  out  2 each  mux selects
- ALUControl  out  ALUCTRL_W  ALU op: ADD=0, SUB=1, AND=2, ORR=3, EOR=4
- BusErr  out  1  sticky bus-timeout error

Behaviour:
- All selects are Moore outputs of state; enables are gated by MemReady and CondExR as listed.
- Reset (synchronous, any cycle including mid-wait):
  - state FETCH; Flags=0; CondExR=0; wait counter=0; BusErr=0.
  - No enable asserted in the reset cycle.
- FETCH:
  - MemReq=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10.
  - IRWrite=PCWrite=MemReady. Stay while !MemReady; go to DECODE when MemReady.
- DECODE:
  - ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - CondExR <= cond(Instr[31:28], Flags): all ARM codes 0000-1110; 1111 evaluates false.
  - Next state: op=01 -> MEMADR; op=00 with I=1 -> EXECUTEI; op=00 with I=0 -> EXECUTER; op=10 -> BRANCH; op=11 -> FETCH (no effect).
- MEMADR:
  - ALUSrcA=0, ALUSrcB=01, ALUControl=ADD.
  - L=1 -> MEMRD, L=0 -> MEMWR; if CondExR=0 -> FETCH.
- MEMRD: MemReq=1, AdrSrc=1; wait for MemReady, then MEMWB.
- MEMWB: ResultSrc=01; RegWrite=1; PCWrite=1 if Rd=15; then FETCH.
- MEMWR: MemReq=MemWrite=1, AdrSrc=1; held until MemReady, then FETCH.
- EXECUTER / EXECUTEI:
  - ALUSrcA=0; ALUSrcB=00 (R) or 01 (I).
  - ALUControl decoded from cmd Instr[24:21]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 0001 EOR (only if ALUCTRL_W>=3), 1010 CMP=SUB, 1000 TST=AND.
  - Flag writes, when CondExR=1, at the end of this cycle:
    - S=1 (forced 1 for CMP/TST): Flags[3:2] <= N,Z.
    - Additionally Flags[1:0] <= C,V when the op is ADD/SUB/CMP.
  - Then ALUWB.
- ALUWB:
  - ResultSrc=00.
  - RegWrite=CondExR & !(CMP|TST) & supported; PCWrite also when Rd=15 under the same gating.
  - Then FETCH.
- Unsupported cmd (including EOR at ALUCTRL_W=2): ALUControl=ADD, no register write, no flag write (NOP).
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, PCWrite=CondExR; then FETCH.
- Combinational regardless of state: RegSrc[0]=(op==10), RegSrc[1]=(op==01), ImmSrc=op.
- Wait cycles: outputs held stable; no enable pulses until the MemReady cycle. MemReady outside a request is ignored.

Optional Feature:
- Macro: MC_BUS_TIMEOUT_EN.
- With the macro:
  - A wait counter counts consecutive MemReq & !MemReady cycles and clears on MemReady.
  - When it reaches TIMEOUT_CYC: BusErr <= 1 (sticky), FSM -> HALT.
  - HALT: no enables, MemReq=0; exited only by reset.
- Without the macro: no counter, no HALT state, waits are unbounded, BusErr tied 0.

Decomposition:
- Shared package mc_pkg holds:
  - state enum (FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH, HALT);
  - ALU op constants; cond-code constants; op-field constants.
- Natural sub-module: mc_condcheck, a combinational cond-code evaluator (cond, flags -> CondEx).
- FSM, flag registers and counter stay in the top module.

Test Plan:
- ADD R1,R2,R3 (E0821003) with MemReady always 1:
  - FETCH, DECODE, EXECUTER, ALUWB; IRWrite/PCWrite pulse in cycle 1; RegWrite=1 in cycle 4.
- LDR (E5921004) with MemReady low for 3 cycles in FETCH and 2 in MEMRD:
  - FETCH held 4 cycles; IRWrite pulses once; MEMRD held 3 cycles; RegWrite in MEMWB.
- SUBS R0,R0,#1 giving Z=1, then BEQ (0A000002):
  - Flags Z=1 after EXECUTEI; BRANCH asserts PCWrite=1.
  - Same sequence with Z=0: PCWrite=0.
- CMP R1,#5 (E3510005), ALU result flags 4'b0110:
  - Flags <= 0110; ALUWB has RegWrite=0.
- EOR R1,R2,R3 (E0221003):
  - ALUCTRL_W=3: ALUControl=4 and RegWrite=1.
  - ALUCTRL_W=2: no RegWrite, flags unchanged.
- MC_BUS_TIMEOUT_EN, TIMEOUT_CYC=15:
  - MemReady held 0 in FETCH: BusErr rises after cycle 15, state HALT, MemReq=0.
  - Synchronous reset clears BusErr; next cycle is FETCH.
